// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencer.
package mips_mc_ctrl_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_I_EXEC   = 4'd9,
    ST_I_WB     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12
  } McState;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_ADDI  = 2'b11
  } AluOpT;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } AluSrcBT;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RSVD   = 2'd3
  } PcSrcT;

  // Datapath strobe bundle produced by the output decoder.
  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    PcSrcT   pc_src;
    logic    ir_write;
    logic    mem_read;
    logic    mem_write;
    logic    i_or_d;
    logic    alu_src_a;
    AluSrcBT alu_src_b;
    AluOpT   alu_op;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    instr_done;
    logic    illegal_op;
  } ctrl_strobes_t;

  // True for the opcodes this sequencer knows how to execute.
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  // Dispatch target out of DECODE; unknown opcodes go back to FETCH.
  function automatic McState decode_next(input logic [OP_W-1:0] op);
    McState nxt;
    case (op)
      OP_RTYPE:     nxt = ST_R_EXEC;
      OP_LW, OP_SW: nxt = ST_MEM_ADDR;
      OP_ADDI:      nxt = ST_I_EXEC;
      OP_BEQ:       nxt = ST_BRANCH;
      OP_J:         nxt = ST_JUMP;
      default:      nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Opcode/stall inputs and datapath strobes of the multi-cycle controller.
interface mips_mc_ctrl_if;
  import mips_mc_ctrl_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            stall;

  logic            pc_write;
  logic            pc_write_cond;
  PcSrcT           pc_src;
  logic            ir_write;
  logic            mem_read;
  logic            mem_write;
  logic            i_or_d;
  logic            alu_src_a;
  AluSrcBT         alu_src_b;
  AluOpT           alu_op;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            reg_write;
  logic            instr_done;
  logic            illegal_op;
  logic [3:0]      state_o;

  modport master (
    input  opcode, stall,
    output pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
           i_or_d, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, instr_done, illegal_op, state_o
  );

  modport slave (
    output opcode, stall,
    input  pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
           i_or_d, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, instr_done, illegal_op, state_o
  );

endinterface

// File: rtl/mips_mc_outdec.sv
// Combinational state -> datapath strobe decoder with stall gating.
module mips_mc_outdec
  import mips_mc_ctrl_pkg::*;
(
  input  McState        state,
  input  logic          at_last,
  input  logic          illegal,
  input  logic          stall,
  output ctrl_strobes_t strobes
);

  ctrl_strobes_t dec;

  // Moore decode; at_last marks the final cycle of a wait-stated access.
  always_comb begin
    dec = '0;
    case (state)
      ST_FETCH: begin
        dec.mem_read  = 1'b1;
        dec.alu_src_b = SRCB_FOUR;
        dec.ir_write  = at_last;
        dec.pc_write  = at_last;
      end
      ST_DECODE: begin
        dec.alu_src_b  = SRCB_IMM_SH2;
        dec.illegal_op = illegal;
      end
      ST_MEM_ADDR: begin
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        dec.mem_read = 1'b1;
        dec.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        dec.i_or_d     = 1'b1;
        dec.mem_write  = at_last;
        dec.instr_done = at_last;
      end
      ST_R_EXEC: begin
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = SRCB_RT;
        dec.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        dec.reg_write  = 1'b1;
        dec.reg_dst    = 1'b1;
        dec.instr_done = 1'b1;
      end
      ST_I_EXEC: begin
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = SRCB_IMM;
        dec.alu_op    = ALU_ADDI;
      end
      ST_I_WB: begin
        dec.reg_write  = 1'b1;
        dec.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        dec.alu_src_a     = 1'b1;
        dec.alu_src_b     = SRCB_RT;
        dec.alu_op        = ALU_SUB;
        dec.pc_write_cond = 1'b1;
        dec.pc_src        = PC_ALUOUT;
        dec.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        dec.pc_write   = 1'b1;
        dec.pc_src     = PC_JUMP;
        dec.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // A stalled cycle must not commit anything; mux selects stay as decoded.
  always_comb begin
    strobes = dec;
    if (stall) begin
      strobes.pc_write      = 1'b0;
      strobes.pc_write_cond = 1'b0;
      strobes.ir_write      = 1'b0;
      strobes.reg_write     = 1'b0;
      strobes.mem_write     = 1'b0;
      strobes.instr_done    = 1'b0;
      strobes.illegal_op    = 1'b0;
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS sequencer: state register, wait counter and strobe decode.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (MEM_LAT == 0) ? 1 : $clog2(MEM_LAT + 1);

  McState            state;
  logic [CNT_W-1:0]  cnt;
  logic              at_last;
  logic              illegal;
  ctrl_strobes_t     strobes;

  assign at_last = (cnt == CNT_W'(MEM_LAT));
  assign illegal = !op_supported(bus.opcode);

  // Sequencer; counter clears on every transition and only counts in wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (state == ST_IDLE) begin
      state <= ST_FETCH;
      cnt   <= '0;
    end else if (!bus.stall) begin
      cnt <= '0;
      case (state)
        ST_FETCH: begin
          if (at_last) state <= ST_DECODE;
          else         cnt   <= cnt + CNT_W'(1);
        end
        ST_DECODE:   state <= decode_next(bus.opcode);
        ST_MEM_ADDR: state <= (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD: begin
          if (at_last) state <= ST_MEM_WB;
          else         cnt   <= cnt + CNT_W'(1);
        end
        ST_MEM_WR: begin
          if (at_last) state <= ST_FETCH;
          else         cnt   <= cnt + CNT_W'(1);
        end
        ST_R_EXEC:   state <= ST_R_WB;
        ST_I_EXEC:   state <= ST_I_WB;
        ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP:
                     state <= ST_FETCH;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  mips_mc_outdec u_outdec (
    .state   (state),
    .at_last (at_last),
    .illegal (illegal),
    .stall   (bus.stall),
    .strobes (strobes)
  );

  assign bus.pc_write      = strobes.pc_write;
  assign bus.pc_write_cond = strobes.pc_write_cond;
  assign bus.pc_src        = strobes.pc_src;
  assign bus.ir_write      = strobes.ir_write;
  assign bus.mem_read      = strobes.mem_read;
  assign bus.mem_write     = strobes.mem_write;
  assign bus.i_or_d        = strobes.i_or_d;
  assign bus.alu_src_a     = strobes.alu_src_a;
  assign bus.alu_src_b     = strobes.alu_src_b;
  assign bus.alu_op        = strobes.alu_op;
  assign bus.reg_dst       = strobes.reg_dst;
  assign bus.mem_to_reg    = strobes.mem_to_reg;
  assign bus.reg_write     = strobes.reg_write;
  assign bus.instr_done    = strobes.instr_done;
  assign bus.illegal_op    = strobes.illegal_op;
  assign bus.state_o       = 4'(state);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl at MEM_LAT = 0..3 (one instance each).
module tb_mips_mc_ctrl;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_BAD  = 6'b111111;

  // Per-instruction profile: length from FETCH entry, strobe counts, completion snapshot.
  typedef struct {
    int k;
    int len, ir, mrd, mwr, rw, iord, pcw, pcwc;
    int done, ill, st, pc_src, alu_op, srca, srcb, rd, m2r;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      rst_v   = 4'hF;
  logic [3:0]      stall_v = 4'h0;
  logic [3:0][5:0] op_v    = '0;

  logic [3:0] pcw_v, pcwc_v, irw_v, mrd_v, mwr_v, iord_v, srca_v;
  logic [3:0] rd_v, m2r_v, rw_v, done_v, ill_v;
  logic [3:0][1:0] pcsrc_v, srcb_v, aluop_v;
  logic [3:0][3:0] st_v;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mips_mc_ctrl_if bus();
    assign bus.opcode = op_v[g];
    assign bus.stall  = stall_v[g];
    mips_mc_ctrl #(.MEM_LAT(g)) dut (.clk(clk), .rst(rst_v[g]), .bus(bus));
    assign pcw_v[g]   = bus.pc_write;
    assign pcwc_v[g]  = bus.pc_write_cond;
    assign pcsrc_v[g] = bus.pc_src;
    assign irw_v[g]   = bus.ir_write;
    assign mrd_v[g]   = bus.mem_read;
    assign mwr_v[g]   = bus.mem_write;
    assign iord_v[g]  = bus.i_or_d;
    assign srca_v[g]  = bus.alu_src_a;
    assign srcb_v[g]  = bus.alu_src_b;
    assign aluop_v[g] = bus.alu_op;
    assign rd_v[g]    = bus.reg_dst;
    assign m2r_v[g]   = bus.mem_to_reg;
    assign rw_v[g]    = bus.reg_write;
    assign done_v[g]  = bus.instr_done;
    assign ill_v[g]   = bus.illegal_op;
    assign st_v[g]    = bus.state_o;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t acc[4];
  exp_t e_mon;
  logic [3:0] prev_st[4];
  int   r_trace[4] = '{1, 2, 7, 8};

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  function automatic logic [21:0] obs(input int k);
    return {pcw_v[k], pcwc_v[k], pcsrc_v[k], irw_v[k], mrd_v[k], mwr_v[k],
            iord_v[k], srca_v[k], srcb_v[k], aluop_v[k], rd_v[k], m2r_v[k],
            rw_v[k], done_v[k], ill_v[k], st_v[k]};
  endfunction

  // Hand-derived profile per opcode at latency L (= instance index).
  function automatic exp_t exp_for(input int k, input logic [5:0] op);
    exp_t e;
    int   lat = k;
    e = '{default: 0};
    e.k = k; e.ir = 1; e.pcw = 1; e.mrd = lat + 1; e.done = 1;
    case (op)
      OPC_R:    begin e.len = 4 + lat; e.rw = 1; e.rd = 1; e.st = 8; end
      OPC_LW:   begin e.len = 5 + 2*lat; e.mrd = 2*lat + 2; e.rw = 1;
                      e.iord = lat + 1; e.m2r = 1; e.st = 5; end
      OPC_SW:   begin e.len = 4 + 2*lat; e.mwr = 1; e.iord = lat + 1; e.st = 6; end
      OPC_ADDI: begin e.len = 4 + lat; e.rw = 1; e.st = 10; end
      OPC_BEQ:  begin e.len = 3 + lat; e.pcwc = 1; e.pc_src = 1; e.alu_op = 1;
                      e.srca = 1; e.st = 11; end
      OPC_J:    begin e.len = 3 + lat; e.pcw = 2; e.pc_src = 2; e.st = 12; end
      default:  begin e.len = 2 + lat; e.done = 0; e.ill = 1; e.srcb = 3; e.st = 2; end
    endcase
    return e;
  endfunction

  task automatic issue(input int k, input logic [5:0] op, input int xl, input int xm, input int xi);
    exp_t e;
    e = exp_for(k, op);
    e.len  += xl;
    e.mrd  += xm;
    e.iord += xi;
    sb_q.push_back(e);
    op_v[k] = op;
  endtask

  // Wait for a completion pulse, then one more cycle so DECODE never sees an opcode change.
  task automatic wait_done(input int k);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(done_v[k] || ill_v[k]) && n < 200);
    chk("completion_seen", k, int'(done_v[k] | ill_v[k]), 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_state(input int k, input int st);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (int'(st_v[k]) != st && n < 200);
    chk("reach_state", k, int'(st_v[k]), st);
  endtask

  // Monitor: accumulates strobes from FETCH entry and scores each completion.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst_v[k]) begin
        prev_st[k] = 4'd0;
      end else begin
        if (st_v[k] == 4'd1 && prev_st[k] != 4'd1) acc[k] = '{default: 0};
        acc[k].len  = acc[k].len + 1;
        acc[k].ir   = acc[k].ir   + int'(irw_v[k]);
        acc[k].mrd  = acc[k].mrd  + int'(mrd_v[k]);
        acc[k].mwr  = acc[k].mwr  + int'(mwr_v[k]);
        acc[k].rw   = acc[k].rw   + int'(rw_v[k]);
        acc[k].iord = acc[k].iord + int'(iord_v[k]);
        acc[k].pcw  = acc[k].pcw  + int'(pcw_v[k]);
        acc[k].pcwc = acc[k].pcwc + int'(pcwc_v[k]);
        if (done_v[k] || ill_v[k]) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_completion", k, sb_q.size(), 1);
          end else begin
            e_mon = sb_q.pop_front();
            chk("sb_instance",  k, k, e_mon.k);
            chk("len",          k, acc[k].len,  e_mon.len);
            chk("ir_write_cnt", k, acc[k].ir,   e_mon.ir);
            chk("mem_read_cnt", k, acc[k].mrd,  e_mon.mrd);
            chk("mem_write_cnt",k, acc[k].mwr,  e_mon.mwr);
            chk("reg_write_cnt",k, acc[k].rw,   e_mon.rw);
            chk("i_or_d_cnt",   k, acc[k].iord, e_mon.iord);
            chk("pc_write_cnt", k, acc[k].pcw,  e_mon.pcw);
            chk("pc_wcond_cnt", k, acc[k].pcwc, e_mon.pcwc);
            chk("instr_done",   k, int'(done_v[k]),  e_mon.done);
            chk("illegal_op",   k, int'(ill_v[k]),   e_mon.ill);
            chk("final_state",  k, int'(st_v[k]),    e_mon.st);
            chk("pc_src",       k, int'(pcsrc_v[k]), e_mon.pc_src);
            chk("alu_op",       k, int'(aluop_v[k]), e_mon.alu_op);
            chk("alu_src_a",    k, int'(srca_v[k]),  e_mon.srca);
            chk("alu_src_b",    k, int'(srcb_v[k]),  e_mon.srcb);
            chk("reg_dst",      k, int'(rd_v[k]),    e_mon.rd);
            chk("mem_to_reg",   k, int'(m2r_v[k]),   e_mon.m2r);
          end
        end
        prev_st[k] = st_v[k];
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk("reset_outputs_zero", k, int'(obs(k)), 0);

    // MEM_LAT=0: R-type with state trace, then beq, j, illegal, addi, sw, lw.
    issue(0, OPC_R, 0, 0, 0);
    rst_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("r_state_trace", 0, int'(st_v[0]), r_trace[i]);
    end
    @(negedge clk); #1;
    issue(0, OPC_BEQ,  0, 0, 0); wait_done(0);
    issue(0, OPC_J,    0, 0, 0); wait_done(0);
    issue(0, OPC_BAD,  0, 0, 0); wait_done(0);
    issue(0, OPC_ADDI, 0, 0, 0); wait_done(0);
    issue(0, OPC_SW,   0, 0, 0); wait_done(0);
    issue(0, OPC_LW,   0, 0, 0); wait_done(0);
    rst_v[0] = 1'b1;
    #1 chk("park_outputs_zero", 0, int'(obs(0)), 0);

    // MEM_LAT=1: stall held across reset release; IDLE->FETCH still happens, then FETCH holds once.
    @(negedge clk); #1;
    issue(1, OPC_SW, 1, 1, 0);
    stall_v[1] = 1'b1;
    rst_v[1]   = 1'b0;
    @(negedge clk); #1;
    chk("stall_idle_to_fetch", 1, int'(st_v[1]), 1);
    @(negedge clk); #1;
    chk("stall_fetch_hold", 1, int'(st_v[1]), 1);
    chk("stall_fetch_ir_write", 1, int'(irw_v[1]), 0);
    stall_v[1] = 1'b0;
    wait_done(1);
    issue(1, OPC_LW, 0, 0, 0); wait_done(1);
    rst_v[1] = 1'b1;

    // MEM_LAT=2: lw then R-type.
    @(negedge clk); #1;
    issue(2, OPC_LW, 0, 0, 0);
    rst_v[2] = 1'b0;
    wait_done(2);
    issue(2, OPC_R, 0, 0, 0); wait_done(2);
    rst_v[2] = 1'b1;

    // MEM_LAT=3: lw stalled for 5 cycles in MEM_RD, then reset mid-MEM_WB.
    @(negedge clk); #1;
    issue(3, OPC_LW, 5, 5, 5);
    rst_v[3] = 1'b0;
    wait_state(3, 4);
    stall_v[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall_rd_state", 3, int'(st_v[3]), 4);
      chk("stall_rd_forced_zero", 3,
          int'({pcw_v[3], pcwc_v[3], irw_v[3], rw_v[3], mwr_v[3], done_v[3], ill_v[3]}), 0);
      chk("stall_rd_mem_read", 3, int'(mrd_v[3]), 1);
    end
    stall_v[3] = 1'b0;
    wait_state(3, 5);
    rst_v[3] = 1'b1;
    #1 chk("async_reset_outputs_zero", 3, int'(obs(3)), 0);

    repeat (2) @(negedge clk);
    #1 chk("sb_drained", 0, sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
